// File: rtl/conv_pkg.sv
// Shared constants and types for the convolution stream host.
// Contents:
//   WIDTH, OUT_WIDTH  x/f word width and y word width (both signed)
//   SIZE_X, SIZE_F    x vector length and filter length
//   SIZE_Y            number of results, SIZE_X - SIZE_F + 1
//   state_t           run-control states of the host
package conv_pkg;

    localparam int WIDTH     = 10;
    localparam int OUT_WIDTH = 26;
    localparam int SIZE_X    = 112;
    localparam int SIZE_F    = 49;
    localparam int SIZE_Y    = SIZE_X - SIZE_F + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/conv_stream_host_if.sv
// The three valid/ready streams between the host and the convolution engine.
//   x_data/x_valid/x_ready  x vector, host -> engine
//   f_data/f_valid/f_ready  filter vector, host -> engine
//   y_data/y_valid/y_ready  results, engine -> host
// Modports: master = host side, slave = engine side.
interface conv_stream_host_if
    import conv_pkg::*;
#(
    parameter int DW = WIDTH,
    parameter int OW = OUT_WIDTH
);

    logic [DW-1:0] x_data;
    logic          x_valid;
    logic          x_ready;
    logic [DW-1:0] f_data;
    logic          f_valid;
    logic          f_ready;
    logic [OW-1:0] y_data;
    logic          y_valid;
    logic          y_ready;

    modport master (
        output x_data, x_valid, input x_ready,
        output f_data, f_valid, input f_ready,
        input  y_data, y_valid, output y_ready
    );

    modport slave (
        input  x_data, x_valid, output x_ready,
        input  f_data, f_valid, output f_ready,
        output y_data, y_valid, input y_ready
    );

endinterface

// File: rtl/conv_stream_host_stream_tx.sv
// One outbound stream channel: a LEN-word buffer written by the host and
// streamed out word by word over valid/ready while enabled.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   wr_en/addr/data   host buffer write; addresses >= LEN are dropped
//   clear             restart from word 0 (accepted start)
//   en                channel may present data (run in progress)
//   data/valid/ready  stream handshake
//   sent              all LEN words have been handed over
//   last_hs           the final word is being handed over this cycle
module stream_tx #(
    parameter int DW  = 10,
    parameter int LEN = 112,
    parameter int AW  = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          clear,
    input  logic          en,
    output logic [DW-1:0] data,
    output logic          valid,
    input  logic          ready,
    output logic          sent,
    output logic          last_hs
);

    localparam int MW = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int IW = $clog2(LEN + 1);

    logic [DW-1:0] mem [LEN];
    logic [IW-1:0] idx_q, idx_d;
    logic          sent_q, sent_d;
    logic          wr_ok;
    logic          hs;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        wr_ok   = wr_en && (32'(wr_addr) < LEN);
        valid   = en && (32'(idx_q) < LEN);
        // Index LEN is only reached once valid is low, so data is a don't-care there.
        data    = mem[idx_q[MW-1:0]];
        hs      = valid && ready;
        last_hs = hs && (32'(idx_q) == LEN - 1);
        idx_d   = idx_q;
        sent_d  = sent_q;
        if (clear) begin
            idx_d  = '0;
            sent_d = 1'b0;
        end else if (hs) begin
            idx_d = idx_q + 1'b1;
            if (last_hs) begin
                sent_d = 1'b1;
            end
        end
        sent = sent_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q  <= '0;
            sent_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            sent_q <= sent_d;
        end
    end

    // NOTE: the buffer has no reset; its contents must survive reset and start.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr[MW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/conv_stream_host.sv
// Host-side initiator for the convolution engine's streaming protocol.
// Streams a loaded x vector and filter vector to the engine on start and
// captures the SIZE_Y results into a readable buffer.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   ld_en/sel/addr/data         host buffer load (sel 0 = x, 1 = f), ignored while busy
//   start                       begin a run (ignored while running)
//   busy, done                  run in progress / run complete (held)
//   y_hold                      host-forced backpressure on y
//   y_count                     results captured this run
//   rd_addr, rd_data            result buffer read, one cycle latency
//   s                           x/f/y streams (master side)
module conv_stream_host
    import conv_pkg::*;
#(
    parameter  int WIDTH     = conv_pkg::WIDTH,
    parameter  int OUT_WIDTH = conv_pkg::OUT_WIDTH,
    parameter  int SIZE_X    = conv_pkg::SIZE_X,
    parameter  int SIZE_F    = conv_pkg::SIZE_F,
    localparam int SIZE_Y    = SIZE_X - SIZE_F + 1,
    localparam int AW_X      = $clog2(SIZE_X),
    localparam int AW_Y      = $clog2(SIZE_Y)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ld_en,
    input  logic                 ld_sel,
    input  logic [AW_X-1:0]      ld_addr,
    input  logic [WIDTH-1:0]     ld_data,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    input  logic                 y_hold,
    output logic [AW_Y:0]        y_count,
    input  logic [AW_Y-1:0]      rd_addr,
    output logic [OUT_WIDTH-1:0] rd_data,
    conv_stream_host_if.master   s
);

    state_t                 state_q, state_d;
    logic [AW_Y:0]          y_count_q, y_count_d;
    logic [OUT_WIDTH-1:0]   ybuf [SIZE_Y];
    logic [OUT_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                   run, start_acc, load_ok, x_wr, f_wr;
    logic                   y_rdy, y_hs;
    logic                   x_sent, x_last, f_sent, f_last;

    stream_tx #(.DW(WIDTH), .LEN(SIZE_X), .AW(AW_X)) u_x_tx (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (x_wr),
        .wr_addr (ld_addr),
        .wr_data (ld_data),
        .clear   (start_acc),
        .en      (run),
        .data    (s.x_data),
        .valid   (s.x_valid),
        .ready   (s.x_ready),
        .sent    (x_sent),
        .last_hs (x_last)
    );

    stream_tx #(.DW(WIDTH), .LEN(SIZE_F), .AW(AW_X)) u_f_tx (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (f_wr),
        .wr_addr (ld_addr),
        .wr_data (ld_data),
        .clear   (start_acc),
        .en      (run),
        .data    (s.f_data),
        .valid   (s.f_valid),
        .ready   (s.f_ready),
        .sent    (f_sent),
        .last_hs (f_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state. Completion looks at this cycle's handshakes so done rises
    // one cycle after the final transfer rather than two.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_acc) state_d = RUN;
            RUN:     if ((x_sent || x_last) && (f_sent || f_last) &&
                         (32'(y_count_d) == SIZE_Y)) state_d = DONE;
            DONE:    if (start_acc) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Outputs and strobes decoded from the state.
    always_comb begin
        run       = (state_q == RUN);
        busy      = run;
        done      = (state_q == DONE);
        start_acc = start && !run;
        load_ok   = ld_en && !run;
        x_wr      = load_ok && !ld_sel;
        f_wr      = load_ok && ld_sel;
        y_rdy     = run && !y_hold && (32'(y_count_q) < SIZE_Y);
        y_hs      = s.y_valid && y_rdy;
    end

    always_comb begin
        y_count_d = y_count_q;
        if (start_acc) begin
            y_count_d = '0;
        end else if (y_hs) begin
            y_count_d = y_count_q + 1'b1;
        end
        rd_data_d = ybuf[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            y_count_q <= '0;
        end else begin
            y_count_q <= y_count_d;
        end
    end

    // A write and a read of the same index in one cycle return the old word.
    always_ff @(posedge clk) begin
        if (y_hs) begin
            ybuf[y_count_q[AW_Y-1:0]] <= s.y_data;
        end
        rd_data_q <= rd_data_d;
    end

    assign s.y_ready = y_rdy;
    assign y_count   = y_count_q;
    assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_conv_stream_host.sv
// Self-checking bench for conv_stream_host. The bench plays the convolution
// engine: it sinks x/f, emits results computed from a software convolution
// of its own copy of the buffers, and checks everything through a
// scoreboard monitor.
module tb_conv_stream_host;
    import conv_pkg::*;

    localparam int AW_X = $clog2(SIZE_X);
    localparam int AW_Y = $clog2(SIZE_Y);

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 ld_en = 1'b0;
    logic                 ld_sel = 1'b0;
    logic [AW_X-1:0]      ld_addr = '0;
    logic [WIDTH-1:0]     ld_data = '0;
    logic                 start = 1'b0;
    logic                 busy, done;
    logic                 y_hold = 1'b0;
    logic [AW_Y:0]        y_count;
    logic [AW_Y-1:0]      rd_addr = '0;
    logic [OUT_WIDTH-1:0] rd_data;

    always #5 clk = ~clk;

    conv_stream_host_if #(.DW(WIDTH), .OW(OUT_WIDTH)) sif ();

    conv_stream_host dut (
        .clk     (clk),
        .reset   (reset),
        .ld_en   (ld_en),
        .ld_sel  (ld_sel),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .y_hold  (y_hold),
        .y_count (y_count),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .s       (sif)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state.
    logic [WIDTH-1:0]     mx [SIZE_X];
    logic [WIDTH-1:0]     mf [SIZE_F];
    logic [OUT_WIDTH-1:0] yexp [SIZE_Y];
    logic [WIDTH-1:0]     xq [$];
    logic [WIDTH-1:0]     fq [$];
    bit                   run_active = 1'b0;
    bit                   mon_en = 1'b0;

    int cyc = 0;
    int t0 = 0;
    int x_n = 0, x_first = 0, x_last = 0;
    int f_n = 0, f_first = 0, f_last = 0;
    int y_n = 0, y_last = 0, ycnt_m = 0;
    int xmode = 0, fmode = 0;
    bit y_fast = 1'b1;
    int yi = 0;
    bit y_seen_hs;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ready pattern: 0 = always, 1 = toggling starting high at T+1, else random
    function automatic logic rdy(input int mode);
        if (mode == 0) return 1'b1;
        if (mode == 1) return ((cyc - t0) % 2) == 1;
        return $urandom_range(0, 2) != 0;
    endfunction

    // Engine side: ready generators for x/f.
    initial begin
        sif.x_ready = 1'b0;
        sif.f_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            sif.x_ready = rdy(xmode);
            sif.f_ready = rdy(fmode);
        end
    end

    // Engine side: result source. Outside a run it waves y_valid randomly.
    initial begin
        sif.y_valid = 1'b0;
        sif.y_data  = '0;
        forever begin
            @(negedge clk);
            y_seen_hs = sif.y_valid && sif.y_ready;
            @(posedge clk); #1;
            if (busy !== 1'b1) begin
                yi          = 0;
                sif.y_valid = 1'($urandom_range(0, 1));
                sif.y_data  = OUT_WIDTH'($urandom);
            end else begin
                if (y_seen_hs) yi++;
                if (y_seen_hs || !sif.y_valid)
                    sif.y_valid = (yi < SIZE_Y) && (y_fast || $urandom_range(0, 2) != 0);
                sif.y_data = (yi < SIZE_Y) ? yexp[yi] : '0;
            end
        end
    end

    // Monitor / scoreboard.
    logic [WIDTH-1:0] px_data, pf_data;
    bit px_stall = 1'b0, pf_stall = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (reset) begin
                px_stall = 1'b0;
                pf_stall = 1'b0;
                ycnt_m   = 0;
            end else begin
                if (px_stall) begin
                    check("x_valid_stable", sif.x_valid, 1);
                    check("x_data_stable", sif.x_data, px_data);
                end
                if (pf_stall) begin
                    check("f_valid_stable", sif.f_valid, 1);
                    check("f_data_stable", sif.f_data, pf_data);
                end
                if (sif.x_valid && sif.x_ready) begin
                    check("x_expected_word", xq.size() > 0, 1);
                    if (xq.size() > 0) check("x_word", sif.x_data, xq.pop_front());
                    x_n++;
                    if (x_n == 1) x_first = cyc - t0;
                    x_last = cyc - t0;
                end
                if (sif.f_valid && sif.f_ready) begin
                    check("f_expected_word", fq.size() > 0, 1);
                    if (fq.size() > 0) check("f_word", sif.f_data, fq.pop_front());
                    f_n++;
                    if (f_n == 1) f_first = cyc - t0;
                    f_last = cyc - t0;
                end
                px_stall = sif.x_valid && !sif.x_ready;
                px_data  = sif.x_data;
                pf_stall = sif.f_valid && !sif.f_ready;
                pf_data  = sif.f_data;

                check("y_count", y_count, ycnt_m);
                if (!busy) check("y_ready_outside_run", sif.y_ready, 0);
                if (y_hold) check("y_ready_under_hold", sif.y_ready, 0);
                if (sif.y_valid && sif.y_ready) begin
                    ycnt_m++;
                    y_n++;
                    y_last = cyc - t0;
                end
                if (start && !busy) begin
                    t0 = cyc;
                    x_n = 0; f_n = 0; y_n = 0;
                    x_first = 0; x_last = 0; f_first = 0; f_last = 0; y_last = 0;
                    ycnt_m = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic load(input bit sel, input int addr, input logic [WIDTH-1:0] data);
        ld_en   = 1'b1;
        ld_sel  = sel;
        ld_addr = AW_X'(addr);
        ld_data = data;
        tick();
        ld_en = 1'b0;
        if (!run_active) begin
            if (!sel && addr < SIZE_X) mx[addr] = data;
            if (sel && addr < SIZE_F) mf[addr] = data;
        end
    endtask

    task automatic start_run(input int xm, input int fm, input bit fast);
        int sum;
        xmode  = xm;
        fmode  = fm;
        y_fast = fast;
        for (int i = 0; i < SIZE_Y; i++) begin
            sum = 0;
            for (int k = 0; k < SIZE_F; k++)
                sum += int'($signed(mx[i + k])) * int'($signed(mf[k]));
            yexp[i] = OUT_WIDTH'(sum);
        end
        xq.delete();
        fq.delete();
        for (int i = 0; i < SIZE_X; i++) xq.push_back(mx[i]);
        for (int i = 0; i < SIZE_F; i++) fq.push_back(mf[i]);
        start = 1'b1;
        tick();
        start = 1'b0;
        run_active = 1'b1;
    endtask

    task automatic wait_done();
        int n = 0;
        int dc;
        int lastev;
        while (done !== 1'b1 && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        dc = cyc - t0;
        check("done_reached", done, 1);
        lastev = (x_last > f_last) ? x_last : f_last;
        if (y_last > lastev) lastev = y_last;
        check("done_latency", dc, lastev + 1);
        check("busy_after_done", busy, 0);
        check("y_count_final", y_count, SIZE_Y);
        check("x_handshakes", x_n, SIZE_X);
        check("f_handshakes", f_n, SIZE_F);
        check("y_handshakes", y_n, SIZE_Y);
        check("x_queue_drained", xq.size(), 0);
        check("f_queue_drained", fq.size(), 0);
        run_active = 1'b0;
        tick();
    endtask

    task automatic read_all();
        for (int i = 0; i < SIZE_Y; i++) begin
            rd_addr = AW_Y'(i);
            tick();
            check($sformatf("ybuf[%0d]", i), rd_data, yexp[i]);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_x_valid", sif.x_valid, 0);
        check("reset_f_valid", sif.f_valid, 0);
        check("reset_y_ready", sif.y_ready, 0);
        check("reset_y_count", y_count, 0);
        mon_en = 1'b1;

        // Full-speed run with all-ones vectors: every result is 49.
        for (int k = 0; k < SIZE_X; k++) load(0, k, 1);
        for (int k = 0; k < SIZE_F; k++) load(1, k, 1);
        start_run(0, 0, 1);
        wait_done();
        check("full_x_first", x_first, 1);
        check("full_x_last", x_last, SIZE_X);
        check("full_f_first", f_first, 1);
        check("full_f_last", f_last, SIZE_F);
        check("full_done", done, 1);
        read_all();
        rd_addr = AW_Y'(5);
        tick();
        check("rd_5_is_49", rd_data, 49);

        // x backpressure with x[k] = k and ready toggling.
        for (int k = 0; k < SIZE_X; k++) load(0, k, WIDTH'(k));
        for (int k = 0; k < SIZE_F; k++) load(1, k, WIDTH'($urandom));
        start_run(1, 0, 1);
        wait_done();
        check("toggle_x_last", x_last, 2 * SIZE_X - 1);
        read_all();

        // y backpressure: y_hold for 20 cycles mid-run, random x/f.
        for (int k = 0; k < SIZE_X; k++) load(0, k, WIDTH'($urandom));
        start_run(2, 0, 1);
        repeat (30) tick();
        y_hold = 1'b1;
        repeat (20) tick();
        y_hold = 1'b0;
        wait_done();
        read_all();

        // start and load during a run are ignored; a second run resends x[3].
        start_run(2, 2, 0);
        repeat (10) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        load(0, 3, 7);
        wait_done();
        start_run(0, 0, 1);
        wait_done();
        read_all();

        // Reset at the 40th x handshake.
        start_run(0, 0, 1);
        n = 0;
        while (x_n < 40 && n < 500) begin
            @(negedge clk); #1;
            n++;
        end
        check("reached_40th_x", x_n, 40);
        reset = 1'b1;
        @(negedge clk); #1;
        check("rst_x_valid", sif.x_valid, 0);
        check("rst_f_valid", sif.f_valid, 0);
        check("rst_y_ready", sif.y_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_y_count", y_count, 0);
        reset = 1'b0;
        xq.delete();
        fq.delete();
        run_active = 1'b0;
        tick();
        start_run(0, 0, 1);
        wait_done();
        check("rerun_x_first", x_first, 1);
        read_all();

        // Out-of-range loads leave both buffers untouched.
        load(0, SIZE_X, 511);
        load(1, SIZE_F, 511);
        start_run(2, 2, 0);
        wait_done();
        read_all();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/conv_stream_host.md
# conv_stream_host

Host-side initiator for the convolution accelerator's streaming protocol. It holds one x vector (SIZE_X words) and one filter vector (SIZE_F words) loaded by the host. On `start`, it transmits both over independent valid/ready channels into the accelerator's x/f inputs, and collects the SIZE_Y = SIZE_X-SIZE_F+1 results from the accelerator's y output into a readable result buffer. It sits between the test/host register interface and the `conv_112_49`-style engine, forming the opposite end of all three of its stream ports.

## Interface
Parameters:
- WIDTH, 10, x/f word width (signed)
- OUT_WIDTH, 26, y word width (signed)
- SIZE_X, 112, x vector length
- SIZE_F, 49, filter length
- (derived) SIZE_Y = SIZE_X-SIZE_F+1 (64); AW_X = $clog2(SIZE_X); AW_Y = $clog2(SIZE_Y)

Ports (reset is synchronous, active-high; clock is clk):
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ld_en  in  1  host buffer write strobe
- ld_sel  in  1  0 = x buffer, 1 = f buffer
- ld_addr  in  AW_X  word index
- ld_data  in  WIDTH  word to store
- start  in  1  begin a run (single-cycle pulse)
- busy  out  1  run in progress
- done  out  1  run complete; held until next accepted start or reset
- x_data  out  WIDTH  x stream data
- x_valid  out  1  x stream valid
- x_ready  in  1  x stream ready
- f_data  out  WIDTH  f stream data
- f_valid  out  1  f stream valid
- f_ready  in  1  f stream ready
- y_data  in  OUT_WIDTH  result stream data
- y_valid  in  1  result stream valid
- y_ready  out  1  result stream ready
- y_hold  in  1  host-forced backpressure on y
- y_count  out  AW_Y+1  results captured this run
- rd_addr  in  AW_Y  result buffer read index
- rd_data  out  OUT_WIDTH  result word, registered

## Operation
- FSM states and transitions:
  - IDLE: accepted start → RUN.
  - RUN: (x_sent && f_sent && y_count==SIZE_Y) → DONE.
  - DONE: accepted start → RUN.
- start is accepted only in IDLE or DONE. An accepted start clears done, y_count, x_sent and f_sent, and sets both send indices to 0. start during RUN is ignored.
- Host loads:
  - ld_en is honoured only when not busy.
  - ld_addr >= SIZE_X (x) or >= SIZE_F (f) is ignored.
  - Buffers are not cleared by reset or start.
- x and f channels are independent and identical (instance of stream_tx):
  - In RUN, valid=1 while index < length; data = buf[index].
  - Handshake (valid && ready) increments the index.
  - After the handshake of the last word, valid=0 and sent=1.
  - Data and valid must stay stable while valid && !ready.
- y channel:
  - y_ready = (state==RUN) && !y_hold && y_count<SIZE_Y.
  - Handshake writes y_data to ybuf[y_count] and increments y_count.
  - y words arriving before x/f finish are accepted normally.
  - y_valid outside RUN is never acknowledged.
- Result read: rd_data <= ybuf[rd_addr] every cycle, in any state.
- Reset mid-run:
  - Next cycle: state IDLE and all stream valids/ready low.
  - No partial transfer is completed.
  - Contents of the x, f and y buffers are retained.

## Timing
- Reset values: busy=0, done=0, x_valid=0, f_valid=0, y_ready=0, y_count=0. rd_data, x_data and f_data are don't-care.
- start sampled at cycle T → busy=1, x_valid=f_valid=1 carrying word 0, and y_ready=!y_hold, all at T+1.
- Throughput is one word per cycle per channel with ready held high. With x_ready=1 throughout, SIZE_X x handshakes occur in cycles T+1..T+SIZE_X.
- Last handshake at cycle N → valid=0 at N+1.
- Final y handshake at cycle M with both channels already sent → done=1, busy=0 at M+1. If the last x/f handshake comes later, done follows that handshake by one cycle.
- rd_data has 1-cycle latency from rd_addr.
- Write-then-read of the same y index in one cycle returns the old value.

## Structure
- Package conv_pkg holds:
  - localparams WIDTH, OUT_WIDTH, SIZE_X, SIZE_F, SIZE_Y;
  - the state enum {IDLE, RUN, DONE}.
- Sub-module stream_tx (params DW, LEN): local buffer write port, clear/enable, data/valid/ready, sent flag. Instantiated once for x and once for f.
- Top holds the FSM, y capture, y_count and the result buffer.

## Test plan
- Full-speed run:
  - Stimulus: x all 1, f all 1, loopback model emitting 64 y=49; ready held high.
  - Required: x handshakes at T+1..T+112, f handshakes at T+1..T+49, y_count=64, done=1; rd_addr=5 → rd_data=49 next cycle.
- x backpressure:
  - Stimulus: x[k]=k, x_ready toggling 1/0.
  - Required: x_data stable while stalled; words 0..111 seen in order; last x handshake at T+223.
- y backpressure:
  - Stimulus: y_hold=1 for 20 cycles mid-run.
  - Required: y_ready=0 and y_count frozen throughout; resumes on release; ybuf[i]=model y[i] for i=0..63.
- Ignored commands:
  - Stimulus: start and ld_en (x addr 3, data 7) during RUN.
  - Required: run unaffected; a second run sends the original x[3].
- Reset mid-run:
  - Stimulus: reset at the 40th x handshake.
  - Required: next cycle x_valid=f_valid=y_ready=busy=done=0, y_count=0; next start re-sends from word 0.
- Out-of-range loads:
  - Stimulus: x ld_addr=112 and f ld_addr=49 with data 511.
  - Required: no buffer change; streamed words match prior contents.
